// File: rtl/t3_pkg.sv
// Shared definitions for the serial-to-word path and the Fila-side logic.
// Holds the word width and the two-state handshake encoding.
package t3_pkg;

  localparam int unsigned WORD_W = 8;

  typedef enum logic {
    COLLECT  = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/deserializador.sv
// Serial-to-parallel converter: collects WORD_W bits MSB first, then holds the
// word with data_ready high until the downstream Fila acknowledges it.
module deserializador #(
  parameter int unsigned WORD_W = t3_pkg::WORD_W
) (
  input  logic              clock_100khz,
  input  logic              reset,
  input  logic              data_in,
  input  logic              write_in,
  input  logic              ack_in,
  output logic              status_out,
  output logic              data_ready,
  output logic [WORD_W-1:0] data_out
);
  import t3_pkg::*;

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]  shift_q;
  logic [WORD_W-1:0]  shift_d;
  logic [WORD_W-1:0]  data_q;
  logic               status_q;
  logic               ready_q;

  always_comb begin
    shift_d = {shift_q[WORD_W-2:0], data_in};
  end

  // data_q is loaded only on word completion, so it never shows partial words.
  always_ff @(posedge clock_100khz) begin
    if (!reset) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      status_q <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (write_in) begin
            shift_q <= shift_d;
            if (cnt_q == LAST_BIT) begin
              cnt_q    <= '0;
              data_q   <= shift_d;
              state_q  <= WAIT_ACK;
              status_q <= 1'b0;
              ready_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        WAIT_ACK: begin
          if (ack_in) begin
            state_q  <= COLLECT;
            status_q <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= COLLECT;
          status_q <= 1'b1;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign status_out = status_q;
  assign data_ready = ready_q;
  assign data_out   = data_q;

endmodule

// File: tb/tb_deserializador.sv
// Self-checking bench for deserializador: table-driven words plus hand-written
// sequences for back-to-back, ignored-bit and reset corner cases.
module tb_deserializador;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       ack_in;
  logic       status_out;
  logic       data_ready;
  logic [7:0] data_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] sb_q[$];
  logic       prev_dr = 1'b0;

  deserializador #(.WORD_W(8)) dut (
    .clock_100khz(clk),
    .reset       (reset),
    .data_in     (data_in),
    .write_in    (write_in),
    .ack_in      (ack_in),
    .status_out  (status_out),
    .data_ready  (data_ready),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every rising edge of data_ready must deliver the oldest expected word.
  always @(negedge clk) begin
    if (data_ready === 1'b1 && prev_dr !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got word %0h required no word", data_out);
      end else begin
        check("sb_word", 32'(data_out), 32'(sb_q.pop_front()));
      end
    end
    prev_dr <= data_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    write_in = 1'b1;
    ack_in   = 1'b1;
    data_in  = 1'b1;
    step();
    reset    = 1'b1;
    write_in = 1'b0;
    ack_in   = 1'b0;
  endtask

  // gaps[k] inserts an idle cycle before bit k (k=7 is the first, MSB bit).
  task automatic send_word(input logic [7:0] word, input logic [7:0] gaps, input logic ack_gap);
    for (int i = 0; i < 8; i++) begin
      if (gaps[7-i]) begin
        data_in  = ~word[7-i];
        write_in = 1'b0;
        ack_in   = ack_gap;
        step();
      end
      data_in  = word[7-i];
      write_in = 1'b1;
      ack_in   = 1'b0;
      if (i == 7) begin
        check("pre_last_ready", 32'(data_ready), 32'd0);
        sb_q.push_back(word);
      end
      step();
    end
    write_in = 1'b0;
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] gaps;
    logic       ack_gap;
  } vec_t;

  vec_t vecs[6];
  logic [16:0] stream;
  logic [16:0] dr_log;

  initial begin
    vecs[0] = '{word: 8'hA5, gaps: 8'h00, ack_gap: 1'b0};
    vecs[1] = '{word: 8'hA5, gaps: 8'b0101_1011, ack_gap: 1'b1};
    vecs[2] = '{word: 8'h3C, gaps: 8'h00, ack_gap: 1'b0};
    vecs[3] = '{word: 8'h00, gaps: 8'h81, ack_gap: 1'b1};
    vecs[4] = '{word: 8'hFF, gaps: 8'h10, ack_gap: 1'b0};
    vecs[5] = '{word: 8'h01, gaps: 8'h00, ack_gap: 1'b0};

    reset = 1'b0; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
    do_reset();
    check("rst_status", 32'(status_out), 32'd1);
    check("rst_ready",  32'(data_ready), 32'd0);
    check("rst_data",   32'(data_out),   32'd0);

    foreach (vecs[k]) begin
      do_reset();
      send_word(vecs[k].word, vecs[k].gaps, vecs[k].ack_gap);
      check("vec_ready",  32'(data_ready), 32'd1);
      check("vec_status", 32'(status_out), 32'd0);
      check("vec_data",   32'(data_out),   32'(vecs[k].word));
      for (int j = 0; j < 3; j++) begin
        data_in  = ~data_in;
        write_in = 1'b1;
        step();
      end
      check("vec_hold", 32'(data_out), 32'(vecs[k].word));
      write_in = 1'b0;
      ack_in   = 1'b1;
      step();
      ack_in   = 1'b0;
      check("vec_ack_ready",  32'(data_ready), 32'd0);
      check("vec_ack_status", 32'(status_out), 32'd1);
      check("vec_keep_data",  32'(data_out),   32'(vecs[k].word));
    end

    // Pending word ignores extra bits; the bit coinciding with ack is dropped.
    do_reset();
    send_word(8'h3C, 8'h00, 1'b0);
    for (int j = 0; j < 5; j++) begin
      data_in  = j[0];
      write_in = 1'b1;
      step();
    end
    check("pend_data",  32'(data_out),   32'h3C);
    check("pend_ready", 32'(data_ready), 32'd1);
    data_in  = 1'b0;
    write_in = 1'b1;
    ack_in   = 1'b1;
    step();
    ack_in   = 1'b0;
    send_word(8'hFF, 8'h00, 1'b0);
    check("pend_next_data", 32'(data_out), 32'hFF);

    // ack tied high with continuous bits: two single-cycle pulses, 9 cycles apart.
    do_reset();
    stream   = {8'h01, 1'b1, 8'h80};
    ack_in   = 1'b1;
    write_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = stream[16-i];
      if (i == 7)  sb_q.push_back(8'h01);
      if (i == 16) sb_q.push_back(8'h80);
      step();
      dr_log[i] = data_ready;
    end
    write_in = 1'b0;
    ack_in   = 1'b0;
    check("b2b_pulses", 32'(dr_log), 32'h10080);
    check("b2b_data",   32'(data_out), 32'h80);

    // Reset mid-word discards the partial bits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      data_in  = 1'b1;
      write_in = 1'b1;
      step();
    end
    do_reset();
    check("midrst_status", 32'(status_out), 32'd1);
    send_word(8'hC3, 8'h00, 1'b0);
    check("midrst_data", 32'(data_out), 32'hC3);

    // Reset while a word is pending clears everything.
    reset  = 1'b0;
    ack_in = 1'b0;
    step();
    reset = 1'b1;
    check("waitrst_ready",  32'(data_ready), 32'd0);
    check("waitrst_data",   32'(data_out),   32'd0);
    check("waitrst_status", 32'(status_out), 32'd1);

    step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializador.md
DESERIALIZADOR -- requirements
Module: deserializador

Interface
REQ-001 Parameter WORD_W, default 8, output word width in bits.
REQ-002 clock_100khz  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the clock_100khz rising edge.
REQ-004 data_in  input  1  serial data bit.
REQ-005 write_in  input  1  qualifies data_in; one bit accepted per cycle with write_in=1 and status_out=1.
REQ-006 ack_in  input  1  downstream (Fila) acknowledge; word consumed.
REQ-007 status_out  output  1  1 = ready to accept serial bits; 0 = word pending, bits ignored.
REQ-008 data_ready  output  1  1 = data_out holds a complete valid word.
REQ-009 data_out  output  WORD_W  assembled word; stable while data_ready=1.

Function
REQ-010 Two-state FSM: COLLECT (status_out=1, data_ready=0) and WAIT_ACK (status_out=0, data_ready=1).
REQ-011 In COLLECT, each cycle with write_in=1 shifts data_in into the shift register and increments a 3-bit bit counter.
REQ-012 Bit order MSB first: the first accepted bit ends in data_out[7], the eighth in data_out[0].
REQ-013 Cycles with write_in=0 in COLLECT hold the shift register and counter unchanged; no timeout.
REQ-014 On the cycle accepting the 8th bit (counter=7), the next state is WAIT_ACK, the counter wraps to 0, and data_ready=1 from the following cycle.
REQ-015 Latency: data_ready rises exactly 1 cycle after the edge that samples the 8th bit.
REQ-016 In WAIT_ACK, write_in and data_in are ignored; the shift register, data_out and counter hold.
REQ-017 In WAIT_ACK, ack_in=1 returns the FSM to COLLECT on the next edge; status_out=1 and data_ready=0 from the following cycle.
REQ-018 ack_in in COLLECT is ignored.
REQ-019 ack_in=1 held continuously in WAIT_ACK yields a 1-cycle data_ready pulse.
REQ-020 A write_in=1 in the same cycle as the accepting ack_in is not captured; status_out is still 0 in that cycle.
REQ-021 Back-to-back words with write_in=1 every cycle and ack_in tied high: one word per 9 cycles minimum.
REQ-022 data_out keeps the last completed word after returning to COLLECT until the next word completes; it is not updated bit-by-bit.

Reset
REQ-023 reset=0 at a rising edge forces COLLECT, counter=0, shift register=0, data_out=0, data_ready=0, status_out=1 from the next cycle.
REQ-024 reset has priority over all inputs; a partially received word or a pending unacknowledged word is discarded.
REQ-025 While reset=0, write_in and ack_in have no effect.

Structure
REQ-026 Shared package t3_pkg holds WORD_W and the state typedef (COLLECT, WAIT_ACK), reused by the Fila-side logic.
REQ-027 No sub-module is required; the shift register and counter are inline; clock-domain crossing toward the 10 kHz Fila is outside this block.

Verification
REQ-028 Reset then serial 1,0,1,0,0,1,0,1 with write_in=1 -> data_ready=1 and data_out=8'hA5 one cycle later; status_out=0.
REQ-029 Same bits interleaved with write_in=0 gaps -> data_out=8'hA5; the gaps do not shift the word.
REQ-030 Word 8'h3C pending and 5 extra bits driven with no ack -> data_out stays 8'h3C; after ack_in the next 8 bits 8'hFF -> data_out=8'hFF.
REQ-031 ack_in held high with continuous bits for 8'h01 then 8'h80 -> two 1-cycle data_ready pulses, 9 cycles apart.
REQ-032 reset=0 after 4 of 8 bits, then 8 bits of 8'hC3 -> data_out=8'hC3; the pre-reset bits are lost.
REQ-033 reset=0 while in WAIT_ACK -> next cycle data_ready=0, data_out=0, status_out=1.
